// File: rtl/rob.sv
// In-order reorder buffer: allocates renamed instructions, retires one per cycle in program order.
// Optional ROB_STATS_EN adds saturating retire/squash counters.
package rob_pkg;
  localparam int PREG_W = 7;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] idx;
    logic              ready;
  } p_reg_t;

  typedef struct packed {
    logic   valid;
    p_reg_t rd;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;
endpackage

module rob
  import rob_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BR_DEPTH = 4,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  rinstr_t          rinstr_i,
  input  logic             is_branch_i,
  output logic [IDX_W-1:0] rob_idx_o,
  output logic             rob_full_o,
  output logic             rob_empty_o,
  input  logic             wb_valid_i,
  input  logic [IDX_W-1:0] wb_idx_i,
  input  br_result_t       br_result_i,
  output p_reg_t           p_commit_o
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]      commit_cnt_o,
  output logic [31:0]      flush_cnt_o
`endif
);

  localparam int BR_W  = $clog2(BR_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head, tail, count;
  logic [DEPTH-1:0] ent_vld, ent_done, ent_br, ent_res;
  p_reg_t           ent_rd [DEPTH];
  logic [IDX_W-1:0] brq [BR_DEPTH];
  logic [BR_W:0]    brq_head, brq_tail, brq_count;

  logic [IDX_W-1:0] head_idx, tail_idx, br_idx, br_off;
  logic [PTR_W-1:0] br_ptr, head_nxt, tail_nxt, squash_n;
  logic             br_pop, flush, alloc, retire;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    head_idx    = head[IDX_W-1:0];
    tail_idx    = tail[IDX_W-1:0];
    brq_count   = brq_tail - brq_head;
    rob_full_o  = (count == PTR_W'(DEPTH)) || (brq_count == (BR_W+1)'(BR_DEPTH));
    rob_empty_o = (count == '0);
    rob_idx_o   = tail_idx;

    br_pop = br_result_i.valid && (brq_count != '0);
    br_idx = brq[brq_head[BR_W-1:0]];
    flush  = br_pop && !br_result_i.hit;
    alloc  = rinstr_i.valid && !rob_full_o && !flush;
    // A branch resolving this cycle may retire on the same edge it resolves.
    retire = ent_vld[head_idx] && ent_done[head_idx] &&
             (!ent_br[head_idx] || ent_res[head_idx] || (br_pop && br_idx == head_idx));

    // Distance of the resolving branch from head gives its full wrap-aware pointer.
    br_off   = br_idx - head_idx;
    br_ptr   = head + PTR_W'(br_off);
    squash_n = tail - br_ptr - PTR_W'(1);
    head_nxt = head + PTR_W'(retire);
    tail_nxt = flush ? br_ptr + PTR_W'(1) : tail + PTR_W'(alloc);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ent_vld    <= '0;
      ent_done   <= '0;
      ent_br     <= '0;
      ent_res    <= '0;
      brq_head   <= '0;
      brq_tail   <= '0;
      p_commit_o <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= flush ? (tail_nxt - head_nxt) : (count + PTR_W'(alloc) - PTR_W'(retire));

      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid_i && ent_vld[i] && wb_idx_i == IDX_W'(i)) ent_done[i] <= 1'b1;
        if (br_pop && br_idx == IDX_W'(i)) ent_res[i] <= 1'b1;
        // Anything further from head than the mispredicted branch is younger.
        if (flush && (IDX_W'(i) - head_idx) > br_off) ent_vld[i] <= 1'b0;
        if (retire && head_idx == IDX_W'(i)) ent_vld[i] <= 1'b0;
        if (alloc && tail_idx == IDX_W'(i)) begin
          ent_vld[i]  <= 1'b1;
          ent_done[i] <= 1'b0;
          ent_br[i]   <= is_branch_i;
          ent_res[i]  <= 1'b0;
        end
      end

      if (flush) begin
        brq_head <= brq_tail;
      end else begin
        if (br_pop) brq_head <= brq_head + (BR_W+1)'(1);
        if (alloc && is_branch_i) brq_tail <= brq_tail + (BR_W+1)'(1);
      end

      if (retire) begin
        p_commit_o.valid <= ent_rd[head_idx].valid;
        p_commit_o.idx   <= ent_rd[head_idx].idx;
        p_commit_o.ready <= ent_rd[head_idx].valid;
      end else begin
        p_commit_o <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) ent_rd[tail_idx] <= rinstr_i.rd;
    if (alloc && is_branch_i) brq[brq_tail[BR_W-1:0]] <= tail_idx;
  end

`ifdef ROB_STATS_EN
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (retire) commit_cnt_o <= sat_add(commit_cnt_o, 32'd1);
      if (flush) flush_cnt_o <= sat_add(flush_cnt_o, 32'(squash_n));
    end
  end
`endif

endmodule
